// File: rtl/readout.sv
// Sample RAM readout: pops words newest-first from the MMU and streams their bytes to the host TX.
// Define READOUT_GRPMASK_EN to honour the grp_i byte-lane mask; otherwise every lane is sent.
module readout #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 5
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [DEPTH:0]     cnt_i,
  input  logic [WIDTH/8-1:0] grp_i,
  output logic               mem_read_o,
  input  logic [WIDTH-1:0]   mem_q_i,
  output logic [7:0]         tx_data_o,
  output logic               tx_valid_o,
  input  logic               tx_ready_i,
  output logic               busy_o,
  output logic               done_o
);

  localparam int LANES = WIDTH / 8;
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, SEND, DONE} state_t;

  state_t           state_q, state_d;
  logic [DEPTH:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [LW-1:0]    lane_q, lane_d;
  logic [LW-1:0]    first_lane, next_lane;
  logic             has_next;
  logic [LANES-1:0] lanes_en;

`ifdef READOUT_GRPMASK_EN
  logic [LANES-1:0] grp_q, grp_d;
  logic             has_first;

  assign lanes_en  = grp_q;
  assign has_first = |grp_q;
`else
  logic unused_grp;

  assign lanes_en   = '1;
  assign unused_grp = ^grp_i;
`endif

  // Lowest enabled lane, and the lowest enabled lane above the current one
  always_comb begin
    first_lane = '0;
    next_lane  = '0;
    has_next   = 1'b0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (lanes_en[i]) begin
        first_lane = LW'(i);
        if (i > int'(lane_q)) begin
          next_lane = LW'(i);
          has_next  = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    lane_d  = lane_q;
`ifdef READOUT_GRPMASK_EN
    grp_d   = grp_q;
`endif
    case (state_q)
      IDLE: begin
        if (start_i) begin
          cnt_d = cnt_i;
`ifdef READOUT_GRPMASK_EN
          grp_d = grp_i;
`endif
          state_d = (cnt_i != '0) ? FETCH : DONE;
        end
      end
      FETCH: begin
        cnt_d   = cnt_q - (DEPTH + 1)'(1);
        state_d = WAIT;
      end
      WAIT: begin
        word_d = mem_q_i;
        lane_d = first_lane;
`ifdef READOUT_GRPMASK_EN
        // Fully masked words are still popped so the MMU pointer moves by the full count
        if (has_first) state_d = SEND;
        else           state_d = (cnt_q != '0) ? FETCH : DONE;
`else
        state_d = SEND;
`endif
      end
      SEND: begin
        if (tx_ready_i) begin
          if (has_next) lane_d  = next_lane;
          else          state_d = (cnt_q != '0) ? FETCH : DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
      lane_q  <= '0;
`ifdef READOUT_GRPMASK_EN
      grp_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      lane_q  <= lane_d;
`ifdef READOUT_GRPMASK_EN
      grp_q   <= grp_d;
`endif
    end
  end

  // Outputs depend only on registered state, never on tx_ready_i
  assign mem_read_o = (state_q == FETCH);
  assign tx_valid_o = (state_q == SEND);
  assign busy_o     = (state_q != IDLE);
  assign done_o     = (state_q == DONE);
  assign tx_data_o  = (state_q == SEND) ? word_q[{lane_q, 3'b000} +: 8] : 8'h00;

endmodule

// File: tb/tb_readout.sv
// Scoreboard bench for readout: MMU model feeds words, expected bytes are queued at stimulus time.
module tb_readout;
  localparam int WIDTH = 32;
  localparam int DEPTH = 5;
  localparam int LANES = 4;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b0;
  logic             start_i = 1'b0;
  logic [DEPTH:0]   cnt_i = '0;
  logic [LANES-1:0] grp_i = '0;
  logic             mem_read_o;
  logic [WIDTH-1:0] mem_q_i = '0;
  logic [7:0]       tx_data_o;
  logic             tx_valid_o;
  logic             tx_ready_i = 1'b1;
  logic             busy_o;
  logic             done_o;

  readout #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .cnt_i      (cnt_i),
    .grp_i      (grp_i),
    .mem_read_o (mem_read_o),
    .mem_q_i    (mem_q_i),
    .tx_data_o  (tx_data_o),
    .tx_valid_o (tx_valid_o),
    .tx_ready_i (tx_ready_i),
    .busy_o     (busy_o),
    .done_o     (done_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  int tick = 0;
  int t0 = 0;
  int reads = 0;
  int dones = 0;
  int done_cyc = 0;
  int busy_cyc = 0;
  int read_cyc[$];
  int byte_cyc[$];
  logic [31:0] mmu_q[$];
  logic [7:0]  exp_q[$];
  logic        stall_prev = 1'b0;
  logic [7:0]  prev_data = '0;
  logic        stall_arm = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk_i) tick <= tick + 1;

  // MMU model, handshake monitor and scoreboard, sampled mid-cycle
  always @(negedge clk_i) begin
    if (rst_i) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        checkOutput("hold_valid", 32'(tx_valid_o), 32'd1);
        checkOutput("hold_data", 32'(tx_data_o), 32'(prev_data));
      end
      if (mem_read_o) begin
        reads++;
        read_cyc.push_back(tick - t0);
        if (mmu_q.size() > 0) mem_q_i = mmu_q.pop_front();
        else                  mem_q_i = 32'hDEAD_BEEF;
      end
      if (tx_valid_o && tx_ready_i) begin
        byte_cyc.push_back(tick - t0);
        if (exp_q.size() > 0) checkOutput("byte", 32'(tx_data_o), 32'(exp_q.pop_front()));
        else                  checkOutput("extra_byte", 32'(tx_data_o), 32'hFFFF_FFFF);
      end
      if (done_o) begin
        dones++;
        done_cyc = tick - t0;
      end
      if (busy_o) busy_cyc++;
      stall_prev = tx_valid_o && !tx_ready_i;
      prev_data  = tx_data_o;
    end
  end

  // Holds tx_ready_i low for 5 cycles the first time byte BB is presented while armed
  initial begin
    forever begin
      @(posedge clk_i);
      #1;
      if (stall_arm && tx_valid_o && tx_ready_i && tx_data_o == 8'hBB) begin
        tx_ready_i = 1'b0;
        repeat (5) @(posedge clk_i);
        #1;
        tx_ready_i = 1'b1;
      end
    end
  end

  task automatic applyStimulus(input int n, input logic [3:0] grp,
                               input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                               input int stall, input int restart_at);
    logic [31:0] w[3];
    logic [3:0]  en;
    int lanes, r0, d0, b0, exp_done;
    w = '{w0, w1, w2};
`ifdef READOUT_GRPMASK_EN
    en = grp;
`else
    en = 4'hF;
`endif
    lanes = $countones(en);
    for (int k = 0; k < n; k++) begin
      mmu_q.push_back(w[k]);
      for (int l = 0; l < LANES; l++)
        if (en[l]) exp_q.push_back(w[k][8*l +: 8]);
    end
    read_cyc.delete();
    byte_cyc.delete();
    r0 = reads;
    d0 = dones;
    b0 = busy_cyc;
    @(posedge clk_i);
    #1;
    start_i = 1'b1;
    cnt_i   = n[DEPTH:0];
    grp_i   = grp;
    t0      = tick;
    for (int c = 1; c < 400 && dones == d0; c++) begin
      @(posedge clk_i);
      #1;
      start_i = (c == restart_at);
      cnt_i   = start_i ? 6'd5 : 6'd7;
      grp_i   = 4'h0;
    end
    start_i = 1'b0;
    repeat (10) @(posedge clk_i);
    #1;
    exp_done = (n == 0) ? 1 : 1 + n * (lanes + 2) + stall;
    checkOutput("done_count", 32'(dones - d0), 32'd1);
    checkOutput("done_cycle", 32'(done_cyc), 32'(exp_done));
    checkOutput("read_count", 32'(reads - r0), 32'(n));
    checkOutput("busy_cycles", 32'(busy_cyc - b0), 32'(exp_done));
    checkOutput("bytes_left", 32'(exp_q.size()), 32'd0);
    for (int k = 0; k < read_cyc.size(); k++)
      checkOutput("read_cycle", 32'(read_cyc[k]), 32'(1 + k * (lanes + 2) + ((k > 0) ? stall : 0)));
    if (byte_cyc.size() > 0) checkOutput("first_byte_cycle", 32'(byte_cyc[0]), 32'd3);
    exp_q.delete();
    mmu_q.delete();
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_mem_read"}, 32'(mem_read_o), 32'd0);
    checkOutput({tag, "_tx_valid"}, 32'(tx_valid_o), 32'd0);
    checkOutput({tag, "_tx_data"}, 32'(tx_data_o), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy_o), 32'd0);
    checkOutput({tag, "_done"}, 32'(done_o), 32'd0);
  endtask

  initial begin
    #1 rst_i = 1'b1;
    #2 checkIdleOutputs("reset");
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;

    $display("[TB] baseline");
    applyStimulus(2, 4'hF, 32'hDDCC_BBAA, 32'h4433_2211, 32'h0, 0, 0);

    $display("[TB] backpressure");
    stall_arm = 1'b1;
    applyStimulus(2, 4'hF, 32'hDDCC_BBAA, 32'h4433_2211, 32'h0, 5, 0);
    stall_arm = 1'b0;

    $display("[TB] empty readout");
    applyStimulus(0, 4'hF, 32'h0, 32'h0, 32'h0, 0, 0);

    $display("[TB] lane mask");
    applyStimulus(1, 4'b0101, 32'hDDCC_BBAA, 32'h0, 32'h0, 0, 0);
    applyStimulus(3, 4'b0000, 32'h0403_0201, 32'h0807_0605, 32'h0C0B_0A09, 0, 0);

    $display("[TB] reset mid-operation");
    mmu_q.push_back(32'hDDCC_BBAA);
    mmu_q.push_back(32'h4433_2211);
    exp_q.push_back(8'hAA);
    exp_q.push_back(8'hBB);
    @(posedge clk_i);
    #1;
    start_i = 1'b1;
    cnt_i   = 6'd2;
    grp_i   = 4'hF;
    t0      = tick;
    @(posedge clk_i);
    #1 start_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #3 rst_i = 1'b1;
    #1 checkIdleOutputs("abort");
    repeat (2) @(posedge clk_i);
    #1;
    mmu_q.delete();
    exp_q.delete();
    rst_i = 1'b0;
    applyStimulus(2, 4'hF, 32'hDDCC_BBAA, 32'h4433_2211, 32'h0, 0, 0);

    $display("[TB] start while busy");
    applyStimulus(2, 4'hF, 32'h1357_9BDF, 32'h2468_ACE0, 32'h0, 0, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
